// File: rtl/ar_arbiter.sv
// ar_arbiter: two-master round-robin arbiter for the AXI read-address channel.
//
// Selects M0 (instruction side) or M1 (data side) and presents one AR request
// to the downstream address decoder. The winner's master tag is prefixed onto
// its ARID (4'h1 = M0, 4'h2 = M1). Decoder READY is routed back to the winner
// only. A grant that is not accepted in its first cycle is locked until the
// handshake, so ARVALID_S and the payload cannot change mid-request.
//
// Ports:
//   ACLK, ARESETn                    clock, asynchronous active-low reset
//   AR*_M0 / AR*_M1 (in)             master requests: ID, ADDR, LEN, SIZE, BURST, VALID
//   ARREADY_M0 / ARREADY_M1 (out)    per-master accept
//   ARID_S (out)                     {master tag, ARID}
//   ARADDR_S..ARBURST_S (out)        selected payload
//   ARVALID_S (out), ARREADY_S (in)  handshake with the decoder
//
// The outputs are combinational (zero latency). The only state is the
// lock state and a single round-robin priority bit.
module ar_arbiter #(
   parameter int ID_BITS   = 4,
   parameter int IDS_BITS  = 8,
   parameter int ADDR_BITS = 32,
   parameter int LEN_BITS  = 4,
   parameter int SIZE_BITS = 3
) (
   input  logic                 ACLK,
   input  logic                 ARESETn,
   input  logic [ID_BITS-1:0]   ARID_M0,
   input  logic [ADDR_BITS-1:0] ARADDR_M0,
   input  logic [LEN_BITS-1:0]  ARLEN_M0,
   input  logic [SIZE_BITS-1:0] ARSIZE_M0,
   input  logic [1:0]           ARBURST_M0,
   input  logic                 ARVALID_M0,
   output logic                 ARREADY_M0,
   input  logic [ID_BITS-1:0]   ARID_M1,
   input  logic [ADDR_BITS-1:0] ARADDR_M1,
   input  logic [LEN_BITS-1:0]  ARLEN_M1,
   input  logic [SIZE_BITS-1:0] ARSIZE_M1,
   input  logic [1:0]           ARBURST_M1,
   input  logic                 ARVALID_M1,
   output logic                 ARREADY_M1,
   output logic [IDS_BITS-1:0]  ARID_S,
   output logic [ADDR_BITS-1:0] ARADDR_S,
   output logic [LEN_BITS-1:0]  ARLEN_S,
   output logic [SIZE_BITS-1:0] ARSIZE_S,
   output logic [1:0]           ARBURST_S,
   output logic                 ARVALID_S,
   input  logic                 ARREADY_S
);

   localparam int TAG_BITS = IDS_BITS - ID_BITS;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOCK_M0 = 2'd1,
      LOCK_M1 = 2'd2
   } state_t;

   state_t r_state, w_state_nxt;
   logic   r_prio,  w_prio_nxt;   // 0 favours M0, 1 favours M1
   logic   w_any;                 // some master holds the grant this cycle
   logic   w_sel;                 // granted master index
   logic   w_vld;                 // granted master's VALID, gated by reset
   logic   w_hs;
   logic   w_on;                  // outputs enabled (out of reset, grant present)

   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state <= IDLE;
         r_prio  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_prio  <= w_prio_nxt;
      end
   end

   always_comb begin
      w_any       = 1'b0;
      w_sel       = 1'b0;
      w_state_nxt = r_state;
      w_prio_nxt  = r_prio;
      case (r_state)
         IDLE: begin
            w_any = ARVALID_M0 | ARVALID_M1;
            w_sel = (ARVALID_M0 & ARVALID_M1) ? r_prio : ARVALID_M1;
         end
         LOCK_M0: begin
            w_any = 1'b1;
            w_sel = 1'b0;
         end
         LOCK_M1: begin
            w_any = 1'b1;
            w_sel = 1'b1;
         end
         default: w_state_nxt = IDLE;
      endcase

      // In LOCK the grant stands even if the locked master drops VALID;
      // ARVALID_S then simply follows that master's input.
      w_vld = ARESETn & w_any & (w_sel ? ARVALID_M1 : ARVALID_M0);
      w_hs  = w_vld & ARREADY_S;

      if (w_any) begin
         if (w_hs) begin
            w_state_nxt = IDLE;
            w_prio_nxt  = ~w_sel;
         end else begin
            w_state_nxt = w_sel ? LOCK_M1 : LOCK_M0;
         end
      end
   end

   assign w_on       = ARESETn & w_any;
   assign ARVALID_S  = w_vld;
   assign ARREADY_M0 = w_on & ~w_sel & ARREADY_S;
   assign ARREADY_M1 = w_on &  w_sel & ARREADY_S;
   assign ARID_S     = !w_on ? '0 :
                       w_sel ? {TAG_BITS'(2), ARID_M1} : {TAG_BITS'(1), ARID_M0};
   assign ARADDR_S   = !w_on ? '0 : (w_sel ? ARADDR_M1  : ARADDR_M0);
   assign ARLEN_S    = !w_on ? '0 : (w_sel ? ARLEN_M1   : ARLEN_M0);
   assign ARSIZE_S   = !w_on ? '0 : (w_sel ? ARSIZE_M1  : ARSIZE_M0);
   assign ARBURST_S  = !w_on ? '0 : (w_sel ? ARBURST_M1 : ARBURST_M0);

endmodule

// File: tb/tb_ar_arbiter.sv
// tb_ar_arbiter: scoreboard bench for ar_arbiter. A stimulus process drives
// both masters and the decoder READY each cycle, computes the expected outputs
// from a transaction-level model (who owns the bus, whose turn it is) and
// queues them; a monitor pops and compares on every falling edge.
module tb_ar_arbiter;

   typedef struct packed {
      logic        v;
      logic [3:0]  id;
      logic [31:0] addr;
      logic [3:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } req_t;

   // {ARVALID_S, ARREADY_M0, ARREADY_M1, ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S}
   typedef logic [51:0] obs_t;

   logic        ACLK = 1'b0;
   logic        ARESETn = 1'b0;
   req_t        m0 = '0, m1 = '0;
   logic        ARREADY_S = 1'b0;
   logic        ARREADY_M0, ARREADY_M1, ARVALID_S;
   logic [7:0]  ARID_S;
   logic [31:0] ARADDR_S;
   logic [3:0]  ARLEN_S;
   logic [2:0]  ARSIZE_S;
   logic [1:0]  ARBURST_S;

   ar_arbiter dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .ARID_M0(m0.id), .ARADDR_M0(m0.addr), .ARLEN_M0(m0.len), .ARSIZE_M0(m0.size),
      .ARBURST_M0(m0.burst), .ARVALID_M0(m0.v), .ARREADY_M0(ARREADY_M0),
      .ARID_M1(m1.id), .ARADDR_M1(m1.addr), .ARLEN_M1(m1.len), .ARSIZE_M1(m1.size),
      .ARBURST_M1(m1.burst), .ARVALID_M1(m1.v), .ARREADY_M1(ARREADY_M1),
      .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
      .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S)
   );

   always #5 ACLK = ~ACLK;

   obs_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;
   bit    stim_done = 1'b0;

   // Reference model: which master owns the bus (-1 = nobody) and whose turn.
   int owner = -1;
   int turn  = 0;
   bit hs0, hs1;   // handshake seen by each master in the last step

   function automatic req_t mk(bit v, logic [3:0] id, logic [31:0] addr);
      req_t r;
      r.v     = v;
      r.id    = id;
      r.addr  = addr;
      r.len   = 4'($urandom);
      r.size  = 3'($urandom);
      r.burst = 2'($urandom);
      return r;
   endfunction

   function automatic req_t rnd(bit v);
      return mk(v, 4'($urandom), $urandom);
   endfunction

   task automatic step(input string nm, input bit rst, input req_t a, input req_t b, input bit rdy);
      int   win;
      req_t w;
      obs_t e;
      @(posedge ACLK);
      #1;
      ARESETn = rst; m0 = a; m1 = b; ARREADY_S = rdy;
      #1;
      if (owner >= 0)      win = owner;
      else if (a.v && b.v) win = turn;
      else if (a.v)        win = 0;
      else if (b.v)        win = 1;
      else                 win = -1;
      hs0 = 1'b0; hs1 = 1'b0;
      e = '0;
      if (rst && win >= 0) begin
         w = (win == 1) ? b : a;
         e = {w.v, (win == 0) && rdy, (win == 1) && rdy,
              (win == 1) ? 4'h2 : 4'h1, w.id, w.addr, w.len, w.size, w.burst};
      end
      exp_q.push_back(e);
      name_q.push_back(nm);
      if (!rst) begin
         owner = -1; turn = 0;
      end else if (win >= 0) begin
         if (w.v && rdy) begin
            owner = -1; turn = 1 - win;
            if (win == 0) hs0 = 1'b1; else hs1 = 1'b1;
         end else begin
            owner = win;
         end
      end
   endtask

   // Monitor: the DUT's outputs are present every cycle; compare mid-cycle.
   initial begin
      obs_t  act, e;
      string nm;
      forever begin
         @(negedge ACLK);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            act = {ARVALID_S, ARREADY_M0, ARREADY_M1, ARID_S, ARADDR_S,
                   ARLEN_S, ARSIZE_S, ARBURST_S};
            n_checks++;
            if (act !== e) begin
               n_fail++;
               $display("FAIL %s @%0t: got vld=%b r0=%b r1=%b id=%h addr=%h lls=%h, want vld=%b r0=%b r1=%b id=%h addr=%h lls=%h",
                        nm, $time, act[51], act[50], act[49], act[48:41], act[40:9], act[8:0],
                        e[51], e[50], e[49], e[48:41], e[40:9], e[8:0]);
            end
         end
      end
   end

   initial begin
      req_t idle, p0, p1;
      idle = '0;
      // Reset with both requesting, then release: M0 first.
      p0 = mk(1, 4'h5, 32'h0000_1000);
      p1 = mk(1, 4'h6, 32'h0000_2000);
      step("reset_both_valid", 0, p0, p1, 1);
      step("reset_both_valid", 0, p0, p1, 1);
      step("release_m0_first", 1, p0, p1, 0);
      step("release_m0_accept", 1, p0, p1, 1);
      step("m1_after_m0", 1, idle, p1, 1);
      // Single master M1, slave ready.
      step("idle_gap", 1, idle, idle, 0);
      step("single_m1", 1, idle, mk(1, 4'h3, 32'h0001_0040), 1);
      step("prio_back_m0", 1, rnd(1), rnd(1), 1);
      // Continuous contention with ready: alternate grants.
      for (int i = 0; i < 4; i++) step("round_robin", 1, rnd(1), rnd(1), 1);
      // Lock hold on M0 while M1 arrives.
      step("idle_gap", 1, idle, idle, 0);
      p0 = mk(1, 4'h9, 32'hCAFE_0000);
      p1 = mk(1, 4'hA, 32'hBEEF_0000);
      step("lock_m0_c1", 1, p0, idle, 0);
      step("lock_m0_c2", 1, p0, p1, 0);
      step("lock_m0_c3", 1, p0, p1, 0);
      step("lock_m0_hs", 1, p0, p1, 1);
      step("m1_after_lock", 1, idle, p1, 1);
      // Reset mid-lock on M1.
      step("lock_m1", 1, idle, p1, 0);
      step("lock_m1_hold", 1, p0, p1, 0);
      step("reset_mid_lock", 0, p0, p1, 1);
      step("after_reset_m0", 1, p0, p1, 1);
      step("after_reset_m1", 1, idle, p1, 1);
      // Idle with READY toggling.
      for (int i = 0; i < 6; i++) step("idle_ready_toggle", 1, idle, idle, i[0]);
      step("idle_prio_kept", 1, rnd(1), rnd(1), 1);
      // Locked master drops VALID: lock holds, no handshake on bare READY.
      step("idle_gap", 1, idle, idle, 0);
      p0 = rnd(1);
      step("drop_lock", 1, p0, idle, 0);
      p0.v = 1'b0;
      step("drop_valid", 1, p0, rnd(1), 1);
      p0.v = 1'b1;
      step("drop_resume", 1, p0, rnd(1), 1);
      // Randomised AXI-compliant masters: a request stays put until accepted.
      p0 = idle; p1 = idle; hs0 = 0; hs1 = 0;
      for (int i = 0; i < 600; i++) begin
         bit rst;
         if (hs0 || !p0.v) p0 = ($urandom_range(0, 2) != 0) ? rnd(1) : idle;
         if (hs1 || !p1.v) p1 = ($urandom_range(0, 2) != 0) ? rnd(1) : idle;
         rst = ($urandom_range(0, 79) != 0);
         step("random", rst, p0, p1, ($urandom_range(0, 2) != 0));
         if (!rst) begin p0 = idle; p1 = idle; end
      end
      stim_done = 1'b1;
   end

   initial begin
      int budget;
      budget = 0;
      wait (stim_done);
      while (exp_q.size() > 0 && budget < 10) begin
         @(negedge ACLK);
         budget++;
      end
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/ar_arbiter.md
Name: ar_arbiter

Overview:
Two-master round-robin arbiter for the AXI read-address (AR) channel, sitting directly upstream of the address decoder. It selects one of M0 (instruction side) or M1 (data side) and presents a single AR request to the decoder, with the master index prefixed onto the ID. It routes the decoder's READY back to the winning master only. A grant is held until its handshake completes, so VALID never drops and the payload never changes mid-request.

Parameters:
ID_BITS, 4, master-side ARID width
IDS_BITS, 8, slave-side ID width (= ID_BITS + 4-bit master tag)
ADDR_BITS, 32, address width
LEN_BITS, 4, burst length width
SIZE_BITS, 3, burst size width

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset, asynchronous, active-low
ARID_M0  in  ID_BITS  M0 request ID
ARADDR_M0  in  ADDR_BITS  M0 address
ARLEN_M0  in  LEN_BITS  M0 burst length
ARSIZE_M0  in  SIZE_BITS  M0 burst size
ARBURST_M0  in  2  M0 burst type
ARVALID_M0  in  1  M0 request valid
ARREADY_M0  out  1  M0 accept
ARID_M1, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1, ARVALID_M1  in  as M0  M1 request
ARREADY_M1  out  1  M1 accept
ARID_S  out  IDS_BITS  {tag, ARID}, tag 4'h1 = M0, 4'h2 = M1
ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S  out  as M0  selected payload, to decoder
ARVALID_S  out  1  selected valid, to decoder
ARREADY_S  in  1  READY returned by decoder

Behaviour:
- State register: IDLE, LOCK_M0, LOCK_M1. Priority register prio: 0 favours M0, 1 favours M1.
- Reset (async on ARESETn low): state = IDLE, prio = 0. During reset all outputs are 0: ARVALID_S, ARREADY_M0/M1, ARID_S, and payload.
- IDLE, combinational grant:
  - If only one ARVALID_Mx is high, that master wins.
  - If both are high, the master selected by prio wins.
  - If neither is high, there is no grant, ARVALID_S = 0, and ARID_S/payload = 0.
- The winning grant drives the outputs in the same cycle (zero latency): ARVALID_S = ARVALID of the winner, payload and tagged ID = winner's, ARREADY_Mwin = ARREADY_S. The losing master's ARREADY = 0.
- Handshake in the same cycle (ARVALID_S & ARREADY_S): state stays IDLE, and prio = the other master.
- No handshake: state moves to LOCK_Mwin.
- LOCK_Mx: grant is fixed to Mx regardless of the other master's VALID. Outputs are routed as above.
  - On handshake: state goes to IDLE and prio = other master.
  - Otherwise the state holds.
- A back-to-back request from the same master after its handshake re-arbitrates in IDLE. If the other master is waiting, the other master wins (fairness).
- An AXI-illegal VALID drop by the locked master is not recovered: the state holds LOCK and ARVALID_S follows the input.
- ARREADY_S is ignored when ARVALID_S = 0. No state change occurs on READY without VALID.
- Reset asserted mid-lock: immediate return to IDLE and prio = 0, with no handshake generated.
- There are no registered outputs. The only storage is state (2 bits) and prio (1 bit).

Test Plan:
- Reset: ARESETn = 0 with both ARVALID = 1 -> ARVALID_S = 0, both ARREADY = 0. Release -> M0 granted first cycle (prio = 0).
- Single master, slave ready: M1 ARVALID = 1, ARID_M1 = 4'h3, ARADDR_M1 = 32'h0001_0040, ARREADY_S = 1 -> same-cycle ARVALID_S = 1, ARID_S = 8'h23, ARADDR_S = 32'h0001_0040, ARREADY_M1 = 1; next cycle prio = 0.
- Contention, round-robin: both valid continuously, ARREADY_S = 1 -> grants alternate M0, M1, M0, M1 over 4 cycles, ARID_S tags 1, 2, 1, 2.
- Lock hold: M0 granted with ARREADY_S = 0 for 3 cycles; M1 raises VALID in cycle 2 -> grant stays M0, ARADDR_S is stable, ARREADY_M1 = 0. Handshake in cycle 4 -> M1 granted in cycle 5.
- Reset mid-lock: in LOCK_M1, pulse ARESETn low -> outputs 0. After release with both valid -> M0 granted.
- Idle stability: neither valid, ARREADY_S toggling -> ARVALID_S = 0, both ARREADY = 0, prio unchanged.
